// File: rtl/led_zone_scheduler_if.sv
// led_zone_scheduler_if: bundles the accumulator-side inputs (frame pulse and
// zone sums) and the driver-side colour stream of the LED zone scheduler.
// The master modport is the scheduler's view; slave is the environment's view.
interface led_zone_scheduler_if #(
  parameter int ZONES = 16,
  parameter int SUM_W = 17
);
  logic             frame_done;
  logic [SUM_W-1:0] sum_r [ZONES];
  logic [SUM_W-1:0] sum_g [ZONES];
  logic [SUM_W-1:0] sum_b [ZONES];

  logic             m_valid;
  logic             m_ready;
  logic [23:0]      m_data;
  logic [3:0]       m_zone;
  logic             m_last;

  logic             busy;
  logic             overrun;

  modport master (
    input  frame_done, sum_r, sum_g, sum_b, m_ready,
    output m_valid, m_data, m_zone, m_last, busy, overrun
  );

  modport slave (
    output frame_done, sum_r, sum_g, sum_b, m_ready,
    input  m_valid, m_data, m_zone, m_last, busy, overrun
  );
endinterface

// File: rtl/led_zone_scheduler.sv
// led_zone_scheduler: snapshots 16 RGB zone sums on each end-of-frame pulse,
// converts each to an 8-bit mean (one zone per cycle), then streams the 16
// zone colours to the LED driver over valid/ready. Frames arriving while one
// is still in flight are dropped and flagged on overrun.
// Optional build macro LED_SCHED_STATUS_EN adds frame_cnt/drop_cnt outputs.
module led_zone_scheduler #(
  parameter int ZONES = 16,
  parameter int SUM_W = 17,
  parameter int MUL_K = 5243,
  parameter int MUL_S = 21
) (
  input  logic                  clk,
  input  logic                  rst,
  led_zone_scheduler_if.master  bus
`ifdef LED_SCHED_STATUS_EN
  ,
  output logic [7:0]            frame_cnt,
  output logic [7:0]            drop_cnt
`endif
);

  localparam int          PROD_W    = SUM_W + 13;
  localparam logic [3:0]  LAST_ZONE = 4'(ZONES - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    SEND
  } state_t;

  state_t           state;
  logic [3:0]       zc;

  logic [SUM_W-1:0] snap_r [ZONES];
  logic [SUM_W-1:0] snap_g [ZONES];
  logic [SUM_W-1:0] snap_b [ZONES];
  logic [23:0]      res_buf [ZONES];

  logic             m_valid_q;
  logic [23:0]      m_data_q;
  logic [3:0]       m_zone_q;
  logic             m_last_q;
  logic             busy_q;
  logic             overrun_q;

  logic             xfer;
  logic             last_xfer;
  logic             capture;
  logic             drop_frame;
  logic [23:0]      calc_rgb;
  logic [3:0]       zc_next;

  // Mean of one channel sum: multiply by the reciprocal, truncate, clamp to 255.
  function automatic logic [7:0] scale_mean(input logic [SUM_W-1:0] s);
    logic [PROD_W-1:0] prod;
    logic [PROD_W-1:0] q;
    prod = PROD_W'(s) * PROD_W'(MUL_K);
    q    = prod >> MUL_S;
    return (q > PROD_W'(255)) ? 8'hFF : q[7:0];
  endfunction

  assign xfer       = (state == SEND) && m_valid_q && bus.m_ready;
  assign last_xfer  = xfer && m_last_q;
  assign capture    = bus.frame_done && ((state == IDLE) || last_xfer);
  assign drop_frame = bus.frame_done && !capture;
  assign zc_next    = zc + 4'd1;

  // Colour for the zone currently being converted in CALC.
  always_comb begin
    calc_rgb = {scale_mean(snap_r[zc]), scale_mean(snap_g[zc]), scale_mean(snap_b[zc])};
  end

  // Snapshot all zone sums when a frame is accepted; upstream clears them on this edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ZONES; i++) begin
        snap_r[i] <= '0;
        snap_g[i] <= '0;
        snap_b[i] <= '0;
      end
    end else if (capture) begin
      for (int i = 0; i < ZONES; i++) begin
        snap_r[i] <= bus.sum_r[i];
        snap_g[i] <= bus.sum_g[i];
        snap_b[i] <= bus.sum_b[i];
      end
    end
  end

  // Result buffer filled one zone per cycle during CALC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ZONES; i++) begin
        res_buf[i] <= '0;
      end
    end else if (state == CALC) begin
      res_buf[zc] <= calc_rgb;
    end
  end

  // Sequencer: IDLE waits for a frame, CALC converts zones, SEND streams beats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      zc        <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_zone_q  <= '0;
      m_last_q  <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= drop_frame;
      case (state)
        IDLE: begin
          if (bus.frame_done) begin
            state  <= CALC;
            zc     <= '0;
            busy_q <= 1'b1;
          end
        end
        CALC: begin
          if (zc == LAST_ZONE) begin
            state     <= SEND;
            zc        <= '0;
            m_valid_q <= 1'b1;
            m_data_q  <= res_buf[0];
            m_zone_q  <= '0;
            m_last_q  <= (LAST_ZONE == 4'd0);
          end else begin
            zc <= zc_next;
          end
        end
        SEND: begin
          if (xfer) begin
            if (m_last_q) begin
              m_valid_q <= 1'b0;
              m_last_q  <= 1'b0;
              zc        <= '0;
              if (bus.frame_done) begin
                state  <= CALC;
                busy_q <= 1'b1;
              end else begin
                state  <= IDLE;
                busy_q <= 1'b0;
              end
            end else begin
              zc       <= zc_next;
              m_data_q <= res_buf[zc_next];
              m_zone_q <= zc_next;
              m_last_q <= (zc_next == LAST_ZONE);
            end
          end
        end
        default: begin
          state     <= IDLE;
          zc        <= '0;
          m_valid_q <= 1'b0;
          m_last_q  <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;
  assign bus.m_zone  = m_zone_q;
  assign bus.m_last  = m_last_q;
  assign bus.busy    = busy_q;
  assign bus.overrun = overrun_q;

`ifdef LED_SCHED_STATUS_EN
  // Status counters: delivered frames and dropped frames, both wrapping at 255.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if (last_xfer) begin
        frame_cnt <= frame_cnt + 8'd1;
      end
      if (overrun_q) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_led_zone_scheduler.sv
// tb_led_zone_scheduler: scoreboard bench for led_zone_scheduler. Expected
// beats are queued when a frame is driven and compared as the DUT emits them.
module tb_led_zone_scheduler;

  typedef logic [16:0] sums_t [16];

  typedef struct {
    logic [23:0] data;
    logic [3:0]  zone;
    logic        last;
    int          start;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   exp_frames = 0;
  int   exp_drops = 0;
  bit   front_seen = 1'b0;
  beat_t sb[$];

`ifdef LED_SCHED_STATUS_EN
  logic [7:0] frame_cnt;
  logic [7:0] drop_cnt;
`endif

  led_zone_scheduler_if bus ();

  led_zone_scheduler dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef LED_SCHED_STATUS_EN
    ,
    .frame_cnt(frame_cnt),
    .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Cycle counter: value N during cycle N (between posedges).
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: mean = min(255, (sum*5243) >> 21).
  function automatic logic [7:0] mean8(input logic [16:0] s);
    longint p;
    p = longint'(s) * 64'd5243;
    p = p >>> 21;
    return (p > 255) ? 8'hFF : 8'(p);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  // Pulse frame_done with the given sums in the current cycle; queue the beats if accepted.
  task automatic applyStimulus(input sums_t r, input sums_t g, input sums_t b,
                               input bit accept, output int c);
    beat_t e;
    bus.sum_r = r;
    bus.sum_g = g;
    bus.sum_b = b;
    bus.frame_done = 1'b1;
    c = cyc;
    if (accept) begin
      for (int i = 0; i < 16; i++) begin
        e.data  = {mean8(r[i]), mean8(g[i]), mean8(b[i])};
        e.zone  = 4'(i);
        e.last  = (i == 15);
        e.start = (i == 0) ? c + 17 : -1;
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    bus.frame_done = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus.sum_r[i] = '0;
      bus.sum_g[i] = '0;
      bus.sum_b[i] = '0;
    end
  endtask

  // Advance to the negedge of cycle n.
  task automatic gotoNeg(input int n);
    int guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (cyc < n && guard < 1000);
  endtask

  // Advance to just after the posedge that starts cycle n.
  task automatic gotoCycle(input int n);
    int guard = 0;
    while (cyc < n && guard < 1000) begin
      @(posedge clk);
      #1;
      guard++;
    end
  endtask

  // Wait for the scoreboard to empty, optionally randomising m_ready each cycle.
  task automatic drain(input bit rand_ready, input int bound);
    int n = 0;
    while (sb.size() > 0 && n < bound) begin
      @(posedge clk);
      #1;
      if (rand_ready) bus.m_ready = 1'($urandom_range(0, 1));
      n++;
    end
    if (sb.size() > 0) checkOutput("drain_timeout", 32'(sb.size()), 0);
    bus.m_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every valid cycle the presented beat must match the scoreboard head.
  always @(negedge clk) begin
    if (!rst && bus.m_valid) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_beat", 1, 0);
      end else begin
        if (!front_seen) begin
          front_seen = 1'b1;
          if (sb[0].start >= 0) checkOutput("first_beat_cycle", 32'(cyc), 32'(sb[0].start));
        end
        checkOutput("m_zone", 32'(bus.m_zone), 32'(sb[0].zone));
        checkOutput("m_data", 32'(bus.m_data), 32'(sb[0].data));
        checkOutput("m_last", 32'(bus.m_last), 32'(sb[0].last));
        if (bus.m_ready) begin
          if (sb[0].last) exp_frames++;
          void'(sb.pop_front());
          front_seen = 1'b0;
        end
      end
    end
  end

  initial begin
    sums_t r, g, b;
    int c, c2;

    rst = 1'b1;
    bus.frame_done = 1'b0;
    bus.m_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus.sum_r[i] = '0;
      bus.sum_g[i] = '0;
      bus.sum_b[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_m_valid", 32'(bus.m_valid), 0);
    checkOutput("reset_m_last", 32'(bus.m_last), 0);
    checkOutput("reset_busy", 32'(bus.busy), 0);
    checkOutput("reset_overrun", 32'(bus.overrun), 0);
    checkOutput("reset_m_data", 32'(bus.m_data), 0);
    checkOutput("reset_m_zone", 32'(bus.m_zone), 0);
    @(posedge clk);
    #1;

    // Saturated frame: every channel 0xFF, with busy/valid timing checks.
    bus.m_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      r[i] = 17'd102000; g[i] = 17'd102000; b[i] = 17'd102000;
    end
    applyStimulus(r, g, b, 1'b1, c);
    gotoNeg(c + 1);
    checkOutput("busy_rise", 32'(bus.busy), 1);
    gotoNeg(c + 16);
    checkOutput("valid_low_in_calc", 32'(bus.m_valid), 0);
    gotoNeg(c + 33);
    checkOutput("busy_fall", 32'(bus.busy), 0);
    drain(1'b0, 100);

    // Per-zone ramp: R=400*i, G=47600, B=399.
    for (int i = 0; i < 16; i++) begin
      r[i] = 17'(400 * i); g[i] = 17'd47600; b[i] = 17'd399;
    end
    applyStimulus(r, g, b, 1'b1, c);
    drain(1'b0, 100);

    // Clamp boundary and exact 40000 mean, interleaved across zones.
    for (int i = 0; i < 16; i++) begin
      r[i] = (i % 2 == 0) ? 17'd131071 : 17'd40000;
      g[i] = (i % 2 == 0) ? 17'd40000 : 17'd131071;
      b[i] = 17'd131071;
    end
    applyStimulus(r, g, b, 1'b1, c);
    drain(1'b0, 100);

    // Random data with random back-pressure.
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 16; i++) begin
        r[i] = 17'($urandom_range(131071, 0));
        g[i] = 17'($urandom_range(131071, 0));
        b[i] = 17'($urandom_range(131071, 0));
      end
      applyStimulus(r, g, b, 1'b1, c);
      drain(1'b1, 400);
    end

    // Overrun during CALC, then a frame on the last-beat transfer (no overrun).
    for (int i = 0; i < 16; i++) begin
      r[i] = 17'(800 * i); g[i] = 17'd20000; b[i] = 17'd131071 - 17'(4000 * i);
    end
    applyStimulus(r, g, b, 1'b1, c);
    gotoCycle(c + 10);
    applyStimulus(g, b, r, 1'b0, c2);
    exp_drops++;
    gotoNeg(c + 11);
    checkOutput("overrun_pulse", 32'(bus.overrun), 1);
    gotoNeg(c + 12);
    checkOutput("overrun_one_cycle", 32'(bus.overrun), 0);
    gotoCycle(c + 32);
    applyStimulus(b, r, g, 1'b1, c2);
    gotoNeg(c + 33);
    checkOutput("no_overrun_on_last", 32'(bus.overrun), 0);
    checkOutput("busy_back_to_back", 32'(bus.busy), 1);
    drain(1'b0, 200);

    // Reset during SEND at zone 7 discards the frame.
    applyStimulus(r, g, b, 1'b1, c);
    gotoCycle(c + 24);
    checkOutput("zone_before_reset", 32'(bus.m_zone), 7);
    rst = 1'b1;
    sb.delete();
    front_seen = 1'b0;
    exp_frames = 0;
    exp_drops = 0;
    #1;
    checkOutput("reset_valid_drop", 32'(bus.m_valid), 0);
    checkOutput("reset_busy_drop", 32'(bus.busy), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(b, g, r, 1'b1, c);
    drain(1'b0, 100);

`ifdef LED_SCHED_STATUS_EN
    checkOutput("frame_cnt", 32'(frame_cnt), 32'(exp_frames));
    checkOutput("drop_cnt", 32'(drop_cnt), 32'(exp_drops));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
